// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment codes (a..g, MSB first),
// converter FSM encoding, and the BCD adjust threshold used by the double-dabble engine.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } conv_state_e;

  // Non-decimal nibbles fall back to "0" so a corrupted digit never shows garbage.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_0;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_bin_to_bcd_seq.sv
// Sequential double-dabble converter: accepts a value on valid/ready, runs one shift/add-3
// step per clock, then strobes load_strb for one cycle with the BCD result and overflow sticky.
//
// state   | meaning
// IDLE    | num_ready high, waiting for num_valid
// CONVERT | one shift/add-3 step per cycle, BIN_WIDTH cycles total
// LOAD    | result stable, load_strb high for one cycle
module bin_to_bcd_seq
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    num_valid,
  input  logic [BIN_WIDTH-1:0]    num,
  output logic                    num_ready,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf_sticky,
  output logic                    load_strb
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

  conv_state_e          state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
  logic                 sticky_q, sticky_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= BCD_ADJ_THRESH) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    num_ready = 1'b0;
    load_strb = 1'b0;
    unique case (state_q)
      IDLE: begin
        num_ready = 1'b1;
        if (num_valid) begin
          bin_d    = num;
          bcd_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(BIN_WIDTH - 1);
          state_d  = CONVERT;
        end
      end
      CONVERT: begin
        // A carry out of the top nibble means the value no longer fits in NUM_DIGITS digits.
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
        bin_d = bin_q << 1;
        if (bcd_adj[BCD_W-1]) begin
          sticky_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOAD: begin
        load_strb = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bcd        = bcd_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// N-digit multiplexed seven-segment driver with sequential binary-to-BCD conversion.
// Build option SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks digits left of the most significant non-zero digit.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BIN_WIDTH    = 13,
  parameter int DIGIT_PERIOD = 262144
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  num_valid,
  input  logic [BIN_WIDTH-1:0]  num,
  output logic                  num_ready,
  output logic                  conv_done,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] Anode,
  output logic [6:0]            LED_out
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int PER_W  = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int SCAN_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [BCD_W-1:0]      conv_bcd;
  logic                  conv_ovf;
  logic                  conv_load;

  logic [BCD_W-1:0]      digits_q, digits_d;
  logic                  overflow_q, overflow_d;
  logic                  conv_done_q, conv_done_d;
  logic [PER_W-1:0]      per_q, per_d;
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic                  per_tc;

  logic [NUM_DIGITS-1:0] blank_mask;
  logic [3:0]            sel_digit;
  logic                  sel_blank;
  logic [NUM_DIGITS-1:0] anode_n;

  bin_to_bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .BIN_WIDTH  (BIN_WIDTH)
  ) u_conv (
    .clk        (clk),
    .rst        (rst),
    .num_valid  (num_valid),
    .num        (num),
    .num_ready  (num_ready),
    .bcd        (conv_bcd),
    .ovf_sticky (conv_ovf),
    .load_strb  (conv_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q    <= '0;
      overflow_q  <= 1'b0;
      conv_done_q <= 1'b0;
      per_q       <= '0;
      scan_q      <= '0;
    end else begin
      digits_q    <= digits_d;
      overflow_q  <= overflow_d;
      conv_done_q <= conv_done_d;
      per_q       <= per_d;
      scan_q      <= scan_d;
    end
  end

  // conv_done rises together with the new display contents, one cycle after the load strobe.
  always_comb begin
    digits_d    = digits_q;
    overflow_d  = overflow_q;
    conv_done_d = 1'b0;
    if (conv_load) begin
      digits_d    = conv_bcd;
      overflow_d  = conv_ovf;
      conv_done_d = 1'b1;
    end
  end

  assign per_tc = (per_q == PER_W'(DIGIT_PERIOD - 1));

  always_comb begin
    per_d  = per_q + PER_W'(1);
    scan_d = scan_q;
    if (per_tc) begin
      per_d = '0;
      if (scan_q == SCAN_W'(NUM_DIGITS - 1)) begin
        scan_d = '0;
      end else begin
        scan_d = scan_q + SCAN_W'(1);
      end
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic lead_zero;

  // Walk from the leftmost digit; the rightmost digit is never part of the mask.
  always_comb begin
    blank_mask = '0;
    lead_zero  = 1'b1;
    for (int j = NUM_DIGITS - 1; j > 0; j--) begin
      if (digits_q[4*j +: 4] != 4'd0) begin
        lead_zero = 1'b0;
      end
      blank_mask[j] = lead_zero;
    end
  end
`else
  assign blank_mask = '0;
`endif

  // Scan index 0 is the leftmost digit, which lives in the top nibble / top anode bit.
  always_comb begin
    sel_digit = 4'd0;
    sel_blank = 1'b0;
    anode_n   = '1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (int'(scan_q) == NUM_DIGITS - 1 - j) begin
        sel_digit  = digits_q[4*j +: 4];
        sel_blank  = blank_mask[j];
        anode_n[j] = 1'b0;
      end
    end
  end

  always_comb begin
    if (overflow_q) begin
      LED_out = SEG_DASH;
    end else if (sel_blank) begin
      LED_out = SEG_BLANK;
    end else begin
      LED_out = seg_decode(sel_digit);
    end
  end

  assign Anode     = anode_n;
  assign overflow  = overflow_q;
  assign conv_done = conv_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench: a 4-digit and a 3-digit driver share stimulus; expected display is
// computed from the decimal value with plain arithmetic.
module tb_seven_seg_scan_driver;

  localparam int BW = 13;
  localparam int DP = 4;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          num_valid = 1'b0;
  logic [BW-1:0] num = '0;

  logic       ready4, done4, ovf4;
  logic [3:0] an4;
  logic [6:0] led4;
  logic       ready3, done3, ovf3;
  logic [2:0] an3;
  logic [6:0] led3;

  int tests_run = 0;
  int tests_failed = 0;
  int k = 0;
  int shown = 0;
  logic [6:0] seg_tab [10];

  seven_seg_scan_driver #(.NUM_DIGITS(4), .BIN_WIDTH(BW), .DIGIT_PERIOD(DP)) u_dut4 (
    .clk(clk), .rst(rst), .num_valid(num_valid), .num(num), .num_ready(ready4),
    .conv_done(done4), .overflow(ovf4), .Anode(an4), .LED_out(led4)
  );

  seven_seg_scan_driver #(.NUM_DIGITS(3), .BIN_WIDTH(BW), .DIGIT_PERIOD(DP)) u_dut3 (
    .clk(clk), .rst(rst), .num_valid(num_valid), .num(num), .num_ready(ready3),
    .conv_done(done3), .overflow(ovf3), .Anode(an3), .LED_out(led3)
  );

  always #5 clk = ~clk;

  // Cycles since the last reset edge; both scan counters are a pure function of this.
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int pow10(input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] exp_led(input int v, input int n, input int scan);
    int j;
    j = n - 1 - scan;
    if (v >= pow10(n)) return 7'b1111110;
    if (BLANK_EN && j > 0 && v < pow10(j)) return 7'b1111111;
    return seg_tab[(v / pow10(j)) % 10];
  endfunction

  function automatic logic [31:0] exp_anode(input int n, input int scan);
    logic [31:0] a;
    a = (32'd1 << n) - 32'd1;
    a = a & ~(32'd1 << (n - 1 - scan));
    return a;
  endfunction

  task automatic check_disp();
    int s4, s3;
    s4 = (k / DP) % 4;
    s3 = (k / DP) % 3;
    check("anode4", 32'(an4), exp_anode(4, s4));
    check("led4", 32'(led4), 32'(exp_led(shown, 4, s4)));
    check("ovf4", 32'(ovf4), 32'(shown >= 10000));
    check("anode3", 32'(an3), exp_anode(3, s3));
    check("led3", 32'(led3), 32'(exp_led(shown, 3, s3)));
    check("ovf3", 32'(ovf3), 32'(shown >= 1000));
  endtask

  task automatic wait_done(input int pending);
    for (int c = 1; c <= BW + 1; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("conv_done4", 32'(done4), 32'(c == BW + 1));
      check("conv_done3", 32'(done3), 32'(c == BW + 1));
      check("num_ready", 32'(ready4), 32'(c == BW + 1));
      if (c == BW + 1) shown = pending;
      check_disp();
    end
  endtask

  task automatic send(input int v);
    @(negedge clk);
    num = BW'(v);
    num_valid = 1'b1;
    check("ready_before_send", 32'(ready4), 32'd1);
    @(posedge clk);
    #1 num_valid = 1'b0;
    wait_done(v);
  endtask

  task automatic rotate();
    repeat (4 * DP) begin
      @(negedge clk);
      check("conv_done_quiet", 32'(done4), 32'd0);
      check_disp();
    end
  endtask

  initial begin
    int dir_vals [7];
    int v;
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    dir_vals = '{1234, 8191, 999, 1000, 7, 0, 1005};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_anode4", 32'(an4), 32'b0111);
    check("reset_led4", 32'(led4), 32'b0000001);
    check("reset_ready", 32'(ready4), 32'd1);
    check("reset_ovf", 32'(ovf4), 32'd0);
    check("reset_done", 32'(done4), 32'd0);
    check("reset_anode3", 32'(an3), 32'b011);

    foreach (dir_vals[i]) begin
      send(dir_vals[i]);
      rotate();
    end

    // Value held on num during conversion must be ignored until ready returns.
    @(negedge clk);
    num = BW'(42);
    num_valid = 1'b1;
    @(posedge clk);
    #1 num = BW'(77);
    wait_done(42);
    @(posedge clk);
    #1 num_valid = 1'b0;
    wait_done(77);
    rotate();

    for (int r = 0; r < 10; r++) begin
      v = int'($urandom_range(0, (1 << BW) - 1));
      send(v);
      rotate();
    end

    send(77);
    // Abort a conversion with reset in its fifth cycle.
    @(negedge clk);
    num = BW'(999);
    num_valid = 1'b1;
    @(posedge clk);
    #1 num_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      check("busy_before_abort", 32'(ready4), 32'd0);
      check_disp();
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    shown = 0;
    check("abort_ready", 32'(ready4), 32'd1);
    check("abort_done", 32'(done4), 32'd0);
    check_disp();
    repeat (2 * BW) begin
      @(negedge clk);
      check("abort_no_done4", 32'(done4), 32'd0);
      check("abort_no_done3", 32'(done3), 32'd0);
      check("abort_ready_hold", 32'(ready4), 32'd1);
      check_disp();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
